spoc64_bdo_buffer: RTL and testbench
====================================

SPOC64_BDO_BUFFER -- requirements
Module: spoc64_bdo_buffer

Interface
REQ-001 SHALL have parameter PW, default 32, meaning output word width in bits; only 32 is supported.
REQ-002 SHALL have parameter DEPTH, default 2, meaning FIFO entries; a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low; clock clk.
REQ-005 SHALL have port in_valid, input, 1 bit: the datapath presents a word.
REQ-006 SHALL have port in_ready, output, 1 bit: the buffer accepts the word this cycle.
REQ-007 SHALL have port in_data, input, PW bits: ciphertext, plaintext or tag word from the datapath bdo.
REQ-008 SHALL have port in_size, input, 3 bits: valid bytes in in_data, 0..4.
REQ-009 SHALL have port in_last, input, 1 bit: last data word of the segment.
REQ-010 SHALL have port in_tag, input, 1 bit: the word is a tag word.
REQ-011 SHALL have port bdo_valid, output, 1 bit: output word available.
REQ-012 SHALL have port bdo_ready, input, 1 bit: the post-processor accepts the word.
REQ-013 SHALL have port bdo, output, PW bits: output word.
REQ-014 SHALL have port bdo_valid_bytes, output, 4 bits: byte-valid mask, MSB-first.
REQ-015 SHALL have port end_of_type, output, 1 bit: last word of the segment or tag.
REQ-016 SHALL have port tag_done, output, 1 bit: one-cycle pulse when the second tag word leaves.
REQ-017 SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-018 SHALL accept an input word when in_valid and in_ready are both 1; in_ready = not full (no combinational pass-through).
REQ-019 SHALL pop the head entry when bdo_valid and bdo_ready are both 1; bdo_valid = not empty.
REQ-020 SHALL present a word on bdo exactly one cycle after acceptance into an empty FIFO.
REQ-021 SHALL, on a simultaneous push and pop, leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-022 SHALL map in_size to bdo_valid_bytes as 0->0000, 1->1000, 2->1100, 3->1110, 4->1111; values 5..7 SHALL be treated as 4.
REQ-023 SHALL run an input-side FSM with states IDLE, DATA and TAG:
- IDLE to DATA: a non-tag word is accepted without in_last.
- IDLE to TAG: a tag word is accepted.
- DATA to IDLE: a word is accepted with in_last.
- TAG to IDLE: the second tag word is accepted.
- A non-tag word accepted in IDLE with in_last stays in IDLE.
REQ-024 SHALL force size 4 for tag words, and force end_of_type=1 on the second tag word (first tag word: 0).
REQ-025 SHALL, in TAG state, drop (not store) an accepted non-tag word and set err; in DATA state, treat a tag word the same way.
REQ-026 SHALL store end_of_type per entry as in_last for data words.
REQ-027 SHALL pulse tag_done for exactly one cycle on the pop of an entry that is a tag word with end_of_type=1.

Reset
REQ-028 SHALL, while rst=0, asynchronously set: FIFO empty, FSM=IDLE, bdo_valid=0, bdo=0, bdo_valid_bytes=0, end_of_type=0, tag_done=0, err=0; in_ready SHALL be 0 during reset.
REQ-029 SHALL discard all buffered words on reset mid-operation; on release, FIFO SHALL be empty and in_ready=1 on the first clock.

Configuration
REQ-030 SHALL, with macro SPOC64_BDO_MASK_EN defined, zero the invalid bytes of bdo (bytes beyond in_size, counted from the MSB); without the macro, bdo SHALL equal in_data unchanged.

Structure
REQ-031 SHALL take the FSM state encodings and the in_size-to-mask function from the shared LWC constants package; TAG_WORDS=2 SHALL also be defined there.
REQ-032 SHALL use one sub-module, spoc64_fifo (a parameterised DEPTH x (PW+6) register FIFO); the FSM and masking SHALL live in the top module.

Verification
REQ-033 Bench SHALL check this scenario: a data word 0xAABBCCDD, size 3, last, into the empty FIFO with bdo_ready=1 -> next cycle bdo valid with bdo_valid_bytes=1110, end_of_type=1, and bdo=0xAABBCC00 (mask on) or 0xAABBCCDD (mask off).
REQ-034 Bench SHALL check this scenario: tag words 0x11111111 then 0x22222222, in_size=0 -> both sizes 1111, end_of_type 0 then 1, tag_done pulses once on the second pop.
REQ-035 Bench SHALL check this scenario: bdo_ready=0 and three words pushed -> in_ready=0 after two accepts; the third is held; order is preserved when bdo_ready=1.
REQ-036 Bench SHALL check this scenario: continuous push and pop with DEPTH=2 for 10 words -> throughput of 1 word/cycle after the first, no loss, and correct pointer wrap.
REQ-037 Bench SHALL check this scenario: after the first tag word, a non-tag word 0xDEADBEEF is pushed -> it is dropped, err=1 and stays 1, and the FSM remains in TAG.
REQ-038 Bench SHALL check this scenario: rst asserted with 2 words buffered -> bdo_valid=0 immediately, without waiting for a clock edge; after release, in_ready=1 and the FIFO is empty.

Source files
------------

// File: rtl/spoc64_bdo_buffer_pkg.sv
// ---------------------------------------------------------------------------
// spoc64_bdo_buffer_pkg
// Shared LWC constants for the bdo output buffer:
//   - bdo_state_t : input-side segment tracker states (IDLE / DATA / TAG)
//   - TAG_WORDS   : number of words in a tag (tag_done fires on the last one)
//   - size_to_mask: in_size (0..4, 5..7 saturate to 4) -> MSB-first byte mask
//   - mask_to_bits: expand a 4-bit byte mask to a 32-bit bit mask
// ---------------------------------------------------------------------------
package spoc64_bdo_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAG  = 2'd2
    } bdo_state_t;

    localparam int TAG_WORDS = 2;

    function automatic logic [3:0] size_to_mask(input logic [2:0] size);
        logic [3:0] mask;
        case (size)
            3'd0:    mask = 4'b0000;
            3'd1:    mask = 4'b1000;
            3'd2:    mask = 4'b1100;
            3'd3:    mask = 4'b1110;
            default: mask = 4'b1111;  // 4, and out-of-range 5..7 saturate
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] mask_to_bits(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/spoc64_bdo_buffer_fifo.sv
// ---------------------------------------------------------------------------
// spoc64_fifo
// DEPTH x W register FIFO with first-word-fall-through read port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, rst (async, active-low)
//   push, wdata  : write side; ignored while full
//   pop, rdata   : read side; rdata is the head entry, pop ignored while empty
//   full, empty  : occupancy flags
// ---------------------------------------------------------------------------
module spoc64_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately left unreset; the pointers define which
    // entries are meaningful and the top gates outputs to zero when empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/spoc64_bdo_buffer.sv
// ---------------------------------------------------------------------------
// spoc64_bdo_buffer
// Buffers datapath bdo words (data or tag) towards the post-processor.
// Tracks the segment on the input side (IDLE / DATA / TAG), forces tag words
// to full size, marks end_of_type, drops out-of-place words with a sticky err.
// Optional: define SPOC64_BDO_MASK_EN to zero bytes beyond in_size in bdo;
// otherwise bdo carries in_data unchanged.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_data/in_size/in_last/in_tag : datapath input
//   bdo_valid/bdo_ready/bdo/bdo_valid_bytes/end_of_type : output word
//   tag_done : high in the cycle the final tag word is popped
//   err      : sticky protocol error
// ---------------------------------------------------------------------------
module spoc64_bdo_buffer
    import spoc64_bdo_buffer_pkg::*;
#(
    parameter int PW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    input  logic [2:0]    in_size,
    input  logic          in_last,
    input  logic          in_tag,
    output logic          bdo_valid,
    input  logic          bdo_ready,
    output logic [PW-1:0] bdo,
    output logic [3:0]    bdo_valid_bytes,
    output logic          end_of_type,
    output logic          tag_done,
    output logic          err
);

    // Entry layout: {tag, end_of_type, valid_bytes[3:0], data[PW-1:0]}
    localparam int ENTRY_W = PW + 6;
    localparam logic [1:0] TAG_LAST = 2'(TAG_WORDS - 1);

    bdo_state_t state_q, state_d;
    logic [1:0] tag_cnt_q, tag_cnt_d;  // tag words accepted in current tag
    logic       err_q, err_d;

    logic               fifo_full, fifo_empty;
    logic               accept, drop, push, pop;
    logic [3:0]         wr_bytes;
    logic               wr_eot;
    logic [PW-1:0]      wr_data;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;
    logic               tag_is_last;

    // Held low during reset so nothing is accepted before the buffer is live.
    assign in_ready    = rst && !fifo_full;
    assign accept      = in_valid && in_ready;
    assign tag_is_last = (tag_cnt_q == TAG_LAST);

    always_comb begin
        state_d   = state_q;
        tag_cnt_d = tag_cnt_q;
        err_d     = err_q;
        drop      = 1'b0;
        wr_bytes  = size_to_mask(in_size);
        wr_eot    = in_last;
        if (in_tag) begin
            wr_bytes = 4'b1111;
            wr_eot   = tag_is_last;
        end
        if (accept) begin
            case (state_q)
                ST_IDLE, ST_TAG: begin
                    if (in_tag) begin
                        if (tag_is_last) begin
                            state_d   = ST_IDLE;
                            tag_cnt_d = '0;
                        end else begin
                            state_d   = ST_TAG;
                            tag_cnt_d = tag_cnt_q + 2'd1;
                        end
                    end else if (state_q == ST_TAG) begin
                        drop  = 1'b1;
                        err_d = 1'b1;
                    end else if (!in_last) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (in_tag) begin
                        drop  = 1'b1;
                        err_d = 1'b1;
                    end else if (in_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            tag_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_cnt_q <= tag_cnt_d;
            err_q     <= err_d;
        end
    end

`ifdef SPOC64_BDO_MASK_EN
    assign wr_data = in_data & mask_to_bits(wr_bytes);
`else
    assign wr_data = in_data;
`endif

    assign push     = accept && !drop;
    assign wr_entry = {in_tag, wr_eot, wr_bytes, wr_data};

    spoc64_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bdo_valid = !fifo_empty;
    assign pop       = bdo_valid && bdo_ready;

    // Outputs read zero whenever the FIFO is empty, including during reset.
    assign bdo             = fifo_empty ? '0 : rd_entry[PW-1:0];
    assign bdo_valid_bytes = fifo_empty ? '0 : rd_entry[PW+3:PW];
    assign end_of_type     = !fifo_empty && rd_entry[PW+4];
    assign tag_done        = pop && rd_entry[PW+5] && rd_entry[PW+4];
    assign err             = err_q;

endmodule

// File: tb/tb_spoc64_bdo_buffer.sv
module tb_spoc64_bdo_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  in_size;
    logic        in_last;
    logic        in_tag;
    logic        bdo_valid;
    logic        bdo_ready;
    logic [31:0] bdo;
    logic [3:0]  bdo_valid_bytes;
    logic        end_of_type;
    logic        tag_done;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spoc64_bdo_buffer #(
        .PW    (32),
        .DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_size         (in_size),
        .in_last         (in_last),
        .in_tag          (in_tag),
        .bdo_valid       (bdo_valid),
        .bdo_ready       (bdo_ready),
        .bdo             (bdo),
        .bdo_valid_bytes (bdo_valid_bytes),
        .end_of_type     (end_of_type),
        .tag_done        (tag_done),
        .err             (err)
    );

    typedef struct {
        logic [31:0] data;
        logic [2:0]  size;
        logic        last;
        logic [3:0]  exp_bytes;
        logic [31:0] exp_masked;
        logic        exp_eot;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected bdo for a data word given its raw and hand-masked forms.
    function automatic logic [31:0] exp_bdo(input logic [31:0] raw, input logic [31:0] masked);
`ifdef SPOC64_BDO_MASK_EN
        return masked;
`else
        return raw;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] s,
                         input logic l, input logic t);
        in_valid = v;
        in_data  = d;
        in_size  = s;
        in_last  = l;
        in_tag   = t;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'hAABBCCDD, 3'd3, 1'b1, 4'b1110, 32'hAABBCC00, 1'b1};
        vecs[1] = '{32'h12345678, 3'd0, 1'b0, 4'b0000, 32'h00000000, 1'b0};
        vecs[2] = '{32'h12345678, 3'd1, 1'b0, 4'b1000, 32'h12000000, 1'b0};
        vecs[3] = '{32'h9ABCDEF0, 3'd2, 1'b0, 4'b1100, 32'h9ABC0000, 1'b0};
        vecs[4] = '{32'h0F0F0F0F, 3'd4, 1'b0, 4'b1111, 32'h0F0F0F0F, 1'b0};
        vecs[5] = '{32'h55667788, 3'd5, 1'b0, 4'b1111, 32'h55667788, 1'b0};
        vecs[6] = '{32'h55667788, 3'd7, 1'b1, 4'b1111, 32'h55667788, 1'b1};

        rst       = 1'b0;
        bdo_ready = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);

        // Reset state
        #2;
        check("rst in_ready", in_ready, 0);
        check("rst bdo_valid", bdo_valid, 0);
        check("rst bdo", bdo, 0);
        check("rst bytes", bdo_valid_bytes, 0);
        check("rst eot", end_of_type, 0);
        check("rst tag_done", tag_done, 0);
        check("rst err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release in_ready", in_ready, 1);

        // Table: single data words through an empty FIFO with bdo_ready=1
        bdo_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("v%0d in_ready", i), in_ready, 1);
            drive(1'b1, vecs[i].data, vecs[i].size, vecs[i].last, 1'b0);
            step();
            drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
            check($sformatf("v%0d valid", i), bdo_valid, 1);
            check($sformatf("v%0d bdo", i), bdo, exp_bdo(vecs[i].data, vecs[i].exp_masked));
            check($sformatf("v%0d bytes", i), bdo_valid_bytes, vecs[i].exp_bytes);
            check($sformatf("v%0d eot", i), end_of_type, vecs[i].exp_eot);
            check($sformatf("v%0d tag_done", i), tag_done, 0);
            step();
            check($sformatf("v%0d popped", i), bdo_valid, 0);
        end
        check("table err", err, 0);

        // Tag pair, output stalled, then drained
        bdo_ready = 1'b0;
        drive(1'b1, 32'h11111111, 3'd0, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h22222222, 3'd0, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        check("tag full in_ready", in_ready, 0);
        check("tag1 bdo", bdo, 32'h11111111);
        check("tag1 bytes", bdo_valid_bytes, 4'b1111);
        check("tag1 eot", end_of_type, 0);
        check("tag1 stalled tag_done", tag_done, 0);
        bdo_ready = 1'b1;
        #1;
        check("tag1 pop tag_done", tag_done, 0);
        step();
        check("tag2 bdo", bdo, 32'h22222222);
        check("tag2 bytes", bdo_valid_bytes, 4'b1111);
        check("tag2 eot", end_of_type, 1);
        check("tag2 pop tag_done", tag_done, 1);
        step();
        check("tag after tag_done", tag_done, 0);
        check("tag drained", bdo_valid, 0);
        check("tag err", err, 0);

        // Backpressure: three words with bdo_ready=0
        bdo_ready = 1'b0;
        drive(1'b1, 32'h01010101, 3'd4, 1'b1, 1'b0);
        step();
        check("bp in_ready after 1", in_ready, 1);
        drive(1'b1, 32'h02020202, 3'd4, 1'b1, 1'b0);
        step();
        check("bp in_ready after 2", in_ready, 0);
        drive(1'b1, 32'h03030303, 3'd4, 1'b1, 1'b0);
        step();
        check("bp third held", in_ready, 0);
        check("bp head", bdo, 32'h01010101);
        bdo_ready = 1'b1;
        step();
        check("bp second", bdo, 32'h02020202);
        check("bp in_ready freed", in_ready, 1);
        step();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        check("bp third", bdo, 32'h03030303);
        step();
        check("bp drained", bdo_valid, 0);

        // Streaming: 10 words, one per cycle through DEPTH=2
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'hC0DE0000 + i, 3'd4, 1'b1, 1'b0);
            step();
            check($sformatf("stream%0d valid", i), bdo_valid, 1);
            check($sformatf("stream%0d bdo", i), bdo, 32'hC0DE0000 + i);
            check($sformatf("stream%0d in_ready", i), in_ready, 1);
        end
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        step();
        check("stream drained", bdo_valid, 0);

        // Non-tag word inside a tag is dropped and sets err
        drive(1'b1, 32'h11111111, 3'd0, 1'b0, 1'b1);
        step();
        check("drop tag1 eot", end_of_type, 0);
        drive(1'b1, 32'hDEADBEEF, 3'd4, 1'b1, 1'b0);
        step();
        check("drop word absent", bdo_valid, 0);
        check("drop err", err, 1);
        drive(1'b1, 32'h33333333, 3'd0, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        check("drop still TAG bdo", bdo, 32'h33333333);
        check("drop still TAG eot", end_of_type, 1);
        check("drop tag_done", tag_done, 1);
        step();
        check("drop err sticky", err, 1);

        // Asynchronous reset with two words buffered
        bdo_ready = 1'b0;
        drive(1'b1, 32'hA0A0A0A0, 3'd4, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hB0B0B0B0, 3'd4, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        check("pre-rst valid", bdo_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async rst valid", bdo_valid, 0);
        check("async rst in_ready", in_ready, 0);
        check("async rst bdo", bdo, 0);
        check("async rst err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post-rst in_ready", in_ready, 1);
        check("post-rst empty", bdo_valid, 0);
        drive(1'b1, 32'hC1C1C1C1, 3'd4, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        check("post-rst fresh word", bdo, 32'hC1C1C1C1);
        bdo_ready = 1'b1;
        step();
        check("post-rst drained", bdo_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
